iob_counter_mod: RTL
====================

// Module: iob_counter_mod
// PURPOSE
//  Parametrised up/down modulo counter; successor of the plain free-running counter.
//  Adds load, programmable step, runtime modulo limit, wrap/saturate mode, a terminal-count
//  pulse and a sticky overflow flag. Used for timers, address walkers and event counting.
//  Single clock domain; all state is updated at the rising edge of clk_i.
// PARAMETERS
//  DATA_W   8   counter, step, limit and load width (>=2)
//  RST_VAL  0   value of data_o after rst_i or clr_i (must be <= max_i in use)
// PORTS
//  clk_i       in   1       clock
//  cke_i       in   1       clock enable; 0 = all state holds (rst_i excepted)
//  rst_i       in   1       reset, synchronous, active-high
//  clr_i       in   1       soft clear: data_o<=RST_VAL, ovf_o<=0
//  ld_i        in   1       load ld_val_i
//  ld_val_i    in   DATA_W  load value
//  en_i        in   1       count enable
//  dir_i       in   1       1 = up, 0 = down
//  step_i      in   DATA_W  increment/decrement amount
//  max_i       in   DATA_W  modulo limit; legal range 0..max_i
//  sat_i       in   1       1 = saturate at the limits, 0 = wrap
//  data_o      out  DATA_W  count value (registered)
//  tc_o        out  1       terminal-count pulse (registered)
//  ovf_o       out  1       sticky wrap/saturate flag (registered)
// BEHAVIOUR
//  - Reset: rst_i=1 at an edge -> data_o=RST_VAL, tc_o=0, ovf_o=0. Applies regardless of cke_i.
//  - With cke_i=1, priority is rst_i > clr_i > ld_i > en_i. The lower-priority request that cycle is dropped.
//  - cke_i=0: data_o, ovf_o hold; tc_o forced to 0 next edge.
//  - Load: data_o <= min(ld_val_i, max_i); tc_o=0; ovf_o unchanged.
//  - Count (en_i=1): s = min(step_i, max_i), arithmetic in DATA_W+1 bits.
//    up:   d+s <= max_i -> d+s. Otherwise: wrap -> d+s-max_i-1; sat -> max_i.
//    down: d >= s -> d-s. Otherwise: wrap -> d+max_i+1-s; sat -> 0.
//  - s=0: value holds and no event is raised.
//  - Out-of-range recovery: d > max_i at a count cycle (max_i lowered at runtime) is an event.
//    Result is 0 for wrap+up, max_i for wrap+down or sat+up, 0 for sat+down.
//  - Event (wrap, clamp or recovery): tc_o=1 for exactly the cycle in which the new data_o is visible.
//    ovf_o set to 1 and held until rst_i/clr_i.
//  - Sat mode at a limit with en_i held: tc_o high every enabled cycle while the clamp applies.
//  - tc_o=0 in every cycle with no event, including clear/load cycles.
//  - Latency: 1 cycle from a qualifying edge to data_o/tc_o/ovf_o. No combinational input->output paths,
//    except cmp_o (see CONFIGURATION).
//  - max_i=0: counter pinned at 0; every count with step_i>0 is an event.
// CONFIGURATION
//  IOB_COUNTER_MOD_CMP_EN defined: adds
//    cmp_val_i  in  DATA_W  compare value
//    cmp_o      out 1       combinational (data_o == cmp_val_i)
//  IOB_COUNTER_MOD_CMP_EN undefined: both ports and all compare logic are absent.
//    All other behaviour is identical.
// TESTING (DATA_W=4, RST_VAL=0)
//  1 rst_i=1 one cycle mid-count (data_o=7, ovf_o=1) -> data_o=0, tc_o=0, ovf_o=0 next cycle.
//  2 max=9, step=1, up, wrap, en 12 cycles from 0
//      -> data_o 1..9,0,1,2; tc_o=1 only with data_o=0; ovf_o=1 thereafter.
//  3 sat=1, down, step=2, load 5, en 4 cycles -> data_o 3,1,0,0; tc_o=0,0,1,1; ovf_o=1.
//  4 wrap, down, max=9, load 1, step=3, en 1 cycle -> data_o=8, tc_o=1.
//  5 Priority checks:
//      clr_i+ld_i+en_i together -> data_o=0, tc_o=0.
//      ld_i=1, ld_val_i=15, max=9 -> data_o=9.
//      cke_i=0 with en_i=1 -> data_o holds, tc_o=0.
//  6 Runtime limit change, then compare:
//      data_o=8, max_i changed to 5, up, wrap, en -> data_o=0, tc_o=1.
//      With CMP_EN: cmp_val_i=3, count 0->3 -> cmp_o=1 only while data_o=3.

Source files
------------

// File: rtl/iob_counter_mod.sv
// iob_counter_mod -- up/down modulo counter with load, programmable step,
// runtime modulo limit, wrap/saturate mode, terminal-count pulse and a
// sticky overflow flag.
//
// Optional feature macro: IOB_COUNTER_MOD_CMP_EN
//   defined   -> adds cmp_val_i and a combinational equality output cmp_o
//   undefined -> compare ports and logic are absent
//
// Ports:
//   clk_i      clock
//   cke_i      clock enable; 0 holds data_o/ovf_o and clears tc_o
//   rst_i      synchronous active-high reset (applies regardless of cke_i)
//   clr_i      soft clear to RST_VAL, clears ovf_o
//   ld_i       load min(ld_val_i, max_i)
//   ld_val_i   load value
//   en_i       count enable
//   dir_i      1 = up, 0 = down
//   step_i     increment/decrement amount
//   max_i      modulo limit, legal count range 0..max_i
//   sat_i      1 = saturate at the limits, 0 = wrap
//   cmp_val_i  compare value (only with IOB_COUNTER_MOD_CMP_EN)
//   cmp_o      data_o == cmp_val_i (only with IOB_COUNTER_MOD_CMP_EN)
//   data_o     registered count value
//   tc_o       registered terminal-count pulse
//   ovf_o      registered sticky wrap/saturate flag
module iob_counter_mod #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] ld_val_i,
  input  logic              en_i,
  input  logic              dir_i,
  input  logic [DATA_W-1:0] step_i,
  input  logic [DATA_W-1:0] max_i,
  input  logic              sat_i,
`ifdef IOB_COUNTER_MOD_CMP_EN
  input  logic [DATA_W-1:0] cmp_val_i,
  output logic              cmp_o,
`endif
  output logic [DATA_W-1:0] data_o,
  output logic              tc_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] step_eff;
  logic [DATA_W-1:0] ld_eff;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] nxt;
  logic              evt;

  assign step_eff = (step_i < max_i) ? step_i : max_i;
  assign ld_eff   = (ld_val_i < max_i) ? ld_val_i : max_i;
  // one extra bit so d+s cannot alias below the limit
  assign sum_w    = {1'b0, data_o} + {1'b0, step_eff};

  // Wrap results are computed modulo 2^DATA_W; the true value always lies in
  // 0..max_i, so the truncation is exact.
  always_comb begin
    nxt = data_o;
    evt = 1'b0;
    if (step_i == '0) begin
      nxt = data_o;
      evt = 1'b0;
    end else if (data_o > max_i) begin
      // limit lowered under the counter: recover into range
      evt = 1'b1;
      if (sat_i) nxt = dir_i ? max_i : '0;
      else       nxt = dir_i ? '0 : max_i;
    end else if (max_i == '0) begin
      // step clamps to 0 here, but any nonzero step still counts as an event
      evt = 1'b1;
      nxt = '0;
    end else if (dir_i) begin
      if (sum_w <= {1'b0, max_i}) begin
        nxt = sum_w[DATA_W-1:0];
      end else begin
        evt = 1'b1;
        nxt = sat_i ? max_i : (data_o + step_eff - max_i - 1'b1);
      end
    end else begin
      if (data_o >= step_eff) begin
        nxt = data_o - step_eff;
      end else begin
        evt = 1'b1;
        nxt = sat_i ? '0 : (data_o + max_i + 1'b1 - step_eff);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= RST_VAL;
      tc_o   <= 1'b0;
      ovf_o  <= 1'b0;
    end else if (!cke_i) begin
      tc_o   <= 1'b0;
    end else if (clr_i) begin
      data_o <= RST_VAL;
      tc_o   <= 1'b0;
      ovf_o  <= 1'b0;
    end else if (ld_i) begin
      data_o <= ld_eff;
      tc_o   <= 1'b0;
    end else if (en_i) begin
      data_o <= nxt;
      tc_o   <= evt;
      if (evt) ovf_o <= 1'b1;
    end else begin
      tc_o   <= 1'b0;
    end
  end

`ifdef IOB_COUNTER_MOD_CMP_EN
  assign cmp_o = (data_o == cmp_val_i);
`endif

endmodule
